mdr_unit: RTL

Memory Data Register unit for the datapath. It holds the 32-bit MDR value that drives the bus multiplexer's MDR source input (select code 21). It loads either directly from BusMuxOut or from memory through a request/ready/valid read handshake, and it issues memory writes of its current contents. A small FSM sequences the memory transactions. A timeout counter flags hung transactions. The busy output stalls the control sequencer until the unit returns to idle.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mdr_timeout_counter.sv | 41 ++++
 rtl/mdr_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: MDR FSM states, default data width and
// the bus-mux select code of the MDR source.
// No ports; imported by mdr_unit and its sub-module.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;

  // Bus multiplexer select code that picks the MDR register as bus source.
  localparam logic [4:0] MUX_SEL_MDR = 5'd21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } mdr_state_t;

endpackage

// File: rtl/mdr_timeout_counter.sv
// Transaction watchdog for the MDR unit: counts non-idle cycles and flags
// the last allowed one.
// Ports: clock, clear (sync, active-high), start (zero the count), run
// (count this cycle), expired (count has reached TIMEOUT_CYCLES-1).
module mdr_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // Holding at LAST keeps the counter from wrapping; the owner aborts the
  // transaction on that same edge unless it completes.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mdr_unit.sv
// Memory Data Register: loads from the datapath bus or from memory through a
// req/ready/valid read, and writes its contents to memory.
// Ports: clock/clear, BusMuxOut, MDRin/Read/Write commands, mem_* handshake,
// MDR_q (mux source), busy (stalls sequencer), mem_err (sticky timeout).
module mdr_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MDRin,
  input  logic                  Read,
  input  logic                  Write,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] MDR_q,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  mem_err
);

  mdr_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  err_q, err_d;
  logic                  tmo_start;
  logic                  tmo_expired;

  mdr_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .clear  (clear),
    .start  (tmo_start),
    .run    (state_q != IDLE),
    .expired(tmo_expired)
  );

  // Moore outputs decoded from the state register.
  assign MDR_q     = mdr_q;
  assign mem_wdata = mdr_q;
  assign mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we    = (state_q == WR_REQ);
  assign busy      = (state_q != IDLE);
  assign mem_err   = err_q;

  // In every busy state the completion test comes before the timeout test,
  // so a handshake landing on the last allowed cycle still succeeds.
  always_comb begin
    state_d   = state_q;
    mdr_d     = mdr_q;
    err_d     = err_q;
    tmo_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (MDRin) begin
          err_d = 1'b0;
          if (Read) begin
            state_d   = RD_REQ;
            tmo_start = 1'b1;
          end else begin
            mdr_d = BusMuxOut;
          end
        end else if (Write) begin
          err_d     = 1'b0;
          state_d   = WR_REQ;
          tmo_start = 1'b1;
        end
      end
      RD_REQ: begin
        if (mem_ready) begin
          state_d = RD_WAIT;
        end else if (tmo_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          mdr_d   = mem_rdata;
          state_d = IDLE;
        end else if (tmo_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WR_REQ: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else if (tmo_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

endmodule
